// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time loader for the instruction memory. It takes a byte stream on a
// valid/ready interface, packs each group of four bytes (first byte ends up
// as the most significant byte) into a 32-bit instruction word, and writes
// the words to consecutive memory addresses starting at 0. The cores stay
// stalled through cpu_hold until the requested number of words is written.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   start        one-cycle launch pulse (honoured in IDLE / DONE only)
//   word_count   words to load, sampled with start, saturated to capacity
//   in_valid     stream byte present
//   in_data      stream byte
//   in_ready     loader accepts the byte this cycle
//   imem_we      one-cycle write strobe per word
//   imem_addr    word address of the write
//   imem_wdata   assembled instruction word
//   busy         load in progress
//   done         load complete, held until the next start
//   cpu_hold     stalls the cores, low only once the load is complete
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | after reset, waiting for start
// LOAD   | accepting bytes of the current word
// WRITE  | one-cycle write of the assembled word
// DONE   | requested words written, cores released, waiting for start
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_hold
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0]   CAPACITY  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);

    state_t                state_q;
    logic [1:0]            byte_cnt_q;
    logic [ADDR_WIDTH-1:0] word_idx_q;
    logic [ADDR_WIDTH:0]   count_q;
    // Only the three older bytes need storing; the fourth comes straight
    // from in_data on the cycle the word completes.
    logic [23:0]           shreg_q;

    logic                  in_ready_q;
    logic                  imem_we_q;
    logic [ADDR_WIDTH-1:0] imem_addr_q;
    logic [31:0]           imem_wdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  cpu_hold_q;

    logic [ADDR_WIDTH:0]   count_sat;
    logic                  byte_fire;
    logic                  last_word;

    // Saturating the count keeps the last address at capacity-1, so the
    // word index can never wrap.
    assign count_sat = (word_count > CAPACITY) ? CAPACITY : word_count;
    assign byte_fire = in_valid && in_ready_q;
    assign last_word = (({1'b0, word_idx_q} + COUNT_ONE) == count_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            count_q      <= '0;
            shreg_q      <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        word_idx_q <= '0;
                        byte_cnt_q <= '0;
                        if (word_count == '0) begin
                            state_q    <= S_DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            count_q    <= count_sat;
                            state_q    <= S_LOAD;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                            cpu_hold_q <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (byte_fire) begin
                        shreg_q    <= {shreg_q[15:0], in_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            // Ready drops together with the write strobe so
                            // no byte can be taken during the write cycle.
                            state_q      <= S_WRITE;
                            in_ready_q   <= 1'b0;
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= word_idx_q;
                            imem_wdata_q <= {shreg_q, in_data};
                        end
                    end
                end

                S_WRITE: begin
                    if (last_word) begin
                        state_q    <= S_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end else begin
                        word_idx_q <= word_idx_q + IDX_ONE;
                        byte_cnt_q <= '0;
                        state_q    <= S_LOAD;
                        in_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader with a small memory (4 words) so that count
// saturation is reachable. Expected writes come from a word-level model of
// the byte stream; a monitor pops and compares them on every write strobe.
module tb_imem_loader;
    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW:0]   word_count;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          cpu_hold;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         we_cyc[$];
    logic [7:0] stream[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected word.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (imem_we === 1'b1) begin
            we_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, no write expected", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), e.addr);
                check("write_data", imem_wdata, e.data);
            end
        end
        if (reset_n === 1'b1) begin
            check("hold_is_not_done", 32'(cpu_hold), 32'(!done));
            check("ready_we_exclusive", 32'(in_ready & imem_we), 0);
        end
    end

    // Reference model: the first min(count, capacity, words sent) words of
    // the stream, big-endian, at addresses 0, 1, 2, ...
    task automatic expect_words(input int wc, input int nw_sent);
        int n;
        n = (wc > CAP) ? CAP : wc;
        if (nw_sent < n) n = nw_sent;
        for (int i = 0; i < n; i++)
            exp_q.push_back('{i, {stream[4*i], stream[4*i+1], stream[4*i+2], stream[4*i+3]}});
    endtask

    task automatic make_stream(input int nw);
        stream.delete();
        for (int i = 0; i < 4 * nw; i++) stream.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic fixed_stream();
        stream = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
    endtask

    task automatic do_start(input int wc);
        start      = 1'b1;
        word_count = wc[AW:0];
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Entered just after a negedge; returns just after the negedge that
    // follows the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_accept_timeout: byte 0x%02h not accepted within 50 cycles", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input int nbytes, input int gmin, input int gmax);
        int g;
        for (int i = 0; i < nbytes; i++) begin
            send_byte(stream[i]);
            g = $urandom_range(gmin, gmax);
            for (int k = 0; k < g; k++) begin
                if ((i % 4) != 3) check("ready_mid_word", 32'(in_ready), 1);
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_done(output int dcyc);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: done still %b after 200 cycles", done);
        end
        dcyc = cyc;
    endtask

    task automatic check_timing(input string tag, input int dcyc);
        check({tag, "_write_count"}, we_cyc.size(), 2);
        if (we_cyc.size() == 2) begin
            check({tag, "_write_spacing"}, we_cyc[1] - we_cyc[0], 5);
            check({tag, "_done_latency"}, dcyc - we_cyc[1], 1);
        end
    endtask

    task automatic check_done_state(input string tag);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ready"}, 32'(in_ready), 0);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int dcyc;
        int wc;
        int nw;
        reset_n    = 1'b0;
        start      = 1'b0;
        word_count = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        repeat (2) @(negedge clk);

        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_imem_we", 32'(imem_we), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cpu_hold", 32'(cpu_hold), 1);
        reset_n = 1'b1;
        @(negedge clk);

        // Zero-length load from IDLE.
        we_cyc.delete();
        do_start(0);
        check("zero_done", 32'(done), 1);
        check("zero_cpu_hold", 32'(cpu_hold), 0);
        repeat (3) @(negedge clk);
        check("zero_no_write", we_cyc.size(), 0);

        // Two words at full rate, relaunched from DONE.
        we_cyc.delete();
        fixed_stream();
        expect_words(2, 2);
        do_start(2);
        check("relaunch_done_low", 32'(done), 0);
        check("relaunch_hold_high", 32'(cpu_hold), 1);
        check("relaunch_busy", 32'(busy), 1);
        check("relaunch_ready", 32'(in_ready), 1);
        send_stream(8, 0, 0);
        wait_done(dcyc);
        check_timing("full", dcyc);
        check_done_state("full");

        // Same stream with three idle cycles between bytes.
        we_cyc.delete();
        expect_words(2, 2);
        do_start(2);
        send_stream(8, 3, 3);
        wait_done(dcyc);
        repeat (4) @(negedge clk);
        check("gap_write_count", we_cyc.size(), 2);
        check_done_state("gap");

        // start pulses during LOAD and during WRITE must be ignored.
        we_cyc.delete();
        expect_words(2, 2);
        do_start(2);
        fork
            send_stream(8, 0, 0);
            begin
                int n = 0;
                repeat (2) @(negedge clk);
                do_start(1);
                while (imem_we !== 1'b1 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                do_start(1);
            end
        join
        wait_done(dcyc);
        check_timing("ign", dcyc);
        repeat (4) @(negedge clk);
        check_done_state("ign");

        // Reset after six bytes of a three-word load.
        we_cyc.delete();
        make_stream(3);
        expect_words(3, 1);
        do_start(3);
        send_stream(6, 0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mid_rst_one_write", we_cyc.size(), 1);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_hold", 32'(cpu_hold), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(in_ready), 0);
        repeat (3) @(negedge clk);
        check("mid_rst_no_more", we_cyc.size(), 1);
        make_stream(1);
        expect_words(1, 1);
        do_start(1);
        send_stream(4, 0, 1);
        wait_done(dcyc);
        check_done_state("after_rst");

        // Reset wins over a simultaneous start.
        reset_n    = 1'b0;
        start      = 1'b1;
        word_count = 3'd2;
        @(negedge clk);
        reset_n = 1'b1;
        start   = 1'b0;
        check("rst_prio_ready", 32'(in_ready), 0);
        check("rst_prio_busy", 32'(busy), 0);
        check("rst_prio_done", 32'(done), 0);

        // Count above capacity saturates; surplus bytes are refused.
        we_cyc.delete();
        make_stream(7);
        expect_words(7, 7);
        do_start(7);
        send_stream(4 * CAP, 0, 0);
        wait_done(dcyc);
        check("sat_write_count", we_cyc.size(), CAP);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            check("sat_ready_low", 32'(in_ready), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_done_state("sat");

        // Randomized loads with random gaps.
        for (int t = 0; t < 8; t++) begin
            wc = $urandom_range(1, 7);
            nw = (wc > CAP) ? CAP : wc;
            we_cyc.delete();
            make_stream(nw);
            expect_words(wc, nw);
            do_start(wc);
            send_stream(4 * nw, 0, 2);
            wait_done(dcyc);
            check("rnd_write_count", we_cyc.size(), nw);
            check_done_state("rnd");
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader for the multi-core cpu's instruction memory.
- Receives a byte stream over a valid/ready interface and assembles big-endian 32-bit instruction words.
- Writes each word into the instruction memory write port at consecutive word addresses.
- Holds the cores stalled until the requested word count has been loaded; this is the writer counterpart to the cpu's instruction fetch.

Parameters:
- ADDR_WIDTH, 10, instruction memory word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load, sampled in IDLE or DONE only.
- word_count  input  ADDR_WIDTH+1  number of words to load; sampled with start.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte, MSB byte of each word first.
- in_ready  output  1  loader accepts in_data this cycle.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  assembled instruction word.
- busy  output  1  load in progress.
- done  output  1  load complete, level, held until next start.
- cpu_hold  output  1  stall cores while high.

Behaviour:
- Reset (reset_n low at a clk edge) forces state IDLE. Output reset values:
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, cpu_hold=1.
  - Internal byte_cnt=0, word_idx=0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - start=1 and word_count=0: go to DONE.
  - start=1 and word_count>0: latch count and go to LOAD; word_idx=0, byte_cnt=0.
  - word_count above 2^ADDR_WIDTH saturates to 2^ADDR_WIDTH.
- LOAD:
  - in_ready=1, busy=1.
  - A byte is accepted only on a cycle with in_valid=1 and in_ready=1.
  - Each accepted byte shifts in: shreg <= {shreg[23:0], in_data}; byte_cnt increments.
  - On the 4th accepted byte (byte_cnt==3), go to WRITE.
  - in_valid low stalls indefinitely; no timeout.
- WRITE (exactly one cycle):
  - in_ready=0, imem_we=1, imem_addr=word_idx, imem_wdata=assembled word.
  - Next: word_idx+1 == count goes to DONE; otherwise word_idx increments, byte_cnt=0, back to LOAD.
- DONE:
  - done=1, busy=0, cpu_hold=0, in_ready=0.
  - start=1 re-launches exactly as from IDLE: done and busy update the next cycle, cpu_hold returns to 1.
- cpu_hold is 1 in every state except DONE.
- Latency and throughput:
  - imem_we asserts the cycle after the 4th byte is accepted.
  - Peak rate is 5 cycles per word.
  - done rises the cycle after the final write.
- Bytes presented while in_ready=0 are not consumed; the source must hold them.
- start during LOAD/WRITE is ignored; the running load is unaffected.
- imem_addr and imem_wdata hold their last values outside WRITE; only imem_we qualifies them.
- Address wrap: impossible, since count saturates at capacity and the last address is 2^ADDR_WIDTH-1.
- Reset mid-load:
  - Any partial word is discarded with no write.
  - Words already written remain in memory.
  - done=0, cpu_hold=1.
- Reset has priority over start and in_valid in the same cycle.

Test Plan:
- Reset, start, word_count=2, stream 20,08,00,05,00,00,00,08 at full rate:
  - imem_we pulses twice: addr0=0x20080005, addr1=0x00000008.
  - Writes 5 cycles apart.
  - done=1 and cpu_hold=0 one cycle after the 2nd write.
- Same stream with in_valid low 3 cycles between every byte:
  - Identical writes; no extra imem_we.
  - in_ready never drops during LOAD.
- start with word_count=0:
  - No imem_we; done=1 the next cycle; cpu_hold=0.
- Word_count=3, assert reset_n=0 after 6 bytes:
  - Exactly one write seen (addr0).
  - After reset: state IDLE, done=0, cpu_hold=1.
  - New start with word_count=1 writes addr0 correctly.
- start pulses during LOAD and WRITE of a 2-word load:
  - Ignored; same writes and done timing as the first scenario.
- ADDR_WIDTH=2, word_count=7:
  - Exactly 4 writes, addr 0..3, then done=1.
  - Further bytes are not accepted (in_ready=0).
